wb_arbiter: RTL and testbench

- Schedules the single register-file write port between two result sources.
  - ALU results, buffered in a small in-order FIFO.
  - Memory load responses.
- Generates the writeback select, register write enable, write address and write data that the writeback mux and register file consume.
- Sits between execute/memory stages and the register file in the multi-cycle CPU variant.
- Replaces the fixed m2reg decode with a dynamic per-cycle grant.

---
 rtl/wb_arbiter_pkg.sv | 16 +
 rtl/wb_result_fifo.sv | 67 ++++++
 rtl/wb_arbiter.sv | 108 ++++++++++
 tb/tb_wb_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: default widths, writeback
// select encodings and the hard-wired zero register.
package wb_arbiter_pkg;

    localparam int DW_DEF     = 32;
    localparam int AW_DEF     = 5;
    localparam int DEPTH_DEF  = 2;
    localparam int STARVE_DEF = 4;

    // Same sense as the old m2reg decode: 1 selects load data.
    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_result_fifo.sv
// In-order buffer of pending ALU results {rd, data}. Pushes while full and
// pops while empty are ignored, so callers may drive push/pop ungated.
module wb_result_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [AW-1:0]          push_rd,
    input  logic [DW-1:0]          push_data,
    input  logic                   pop,
    output logic [AW-1:0]          head_rd,
    output logic [DW-1:0]          head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_rd_mem   [DEPTH];
    logic [DW-1:0] r_data_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push    = push && !full;
    assign w_pop     = pop && !empty;
    assign count     = r_count;
    assign head_rd   = r_rd_mem[r_rptr];
    assign head_data = r_data_mem[r_rptr];

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_mem[r_wptr]   <= push_rd;
            r_data_mem[r_wptr] <= push_data;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Per-cycle arbitration of the register-file write port between buffered ALU
// results and load responses, with a starvation guard for the ALU side.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DW           = DW_DEF,
    parameter int AW           = AW_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [AW-1:0]          alu_rd,
    input  logic [DW-1:0]          alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [AW-1:0]          mem_rd,
    input  logic [DW-1:0]          mem_data,
    output logic                   wb_sel,
    output logic                   rf_we,
    output logic [AW-1:0]          rf_waddr,
    output logic [DW-1:0]          rf_wdata,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_force;
    logic          w_mem_grant;
    logic          w_alu_grant;
    logic [AW-1:0] w_head_rd;
    logic [DW-1:0] w_head_data;

    logic [SW-1:0] r_starve;
    logic          r_wb_sel;
    logic          r_rf_we;
    logic [AW-1:0] r_rf_waddr;
    logic [DW-1:0] r_rf_wdata;

    assign alu_ready = !w_full;
    assign w_push    = alu_valid && !w_full;

    wb_result_fifo #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_rd   (alu_rd),
        .push_data (alu_data),
        .pop       (w_alu_grant),
        .head_rd   (w_head_rd),
        .head_data (w_head_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (fifo_count)
    );

    // Loads win by default; the ALU head is forced through once memory has
    // taken STARVE_LIMIT grants in a row while results were waiting.
    assign w_force     = (r_starve == SW'(STARVE_LIMIT)) && !w_empty;
    assign w_mem_grant = mem_valid && !w_force;
    assign w_alu_grant = !w_mem_grant && !w_empty;
    assign mem_ready   = !w_force;

    always_ff @(posedge clk) begin
        if (rst || w_empty || w_alu_grant) begin
            r_starve <= '0;
        end else if (w_mem_grant && (r_starve != SW'(STARVE_LIMIT))) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Address/data/select hold when idle; only the write enable drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_wb_sel   <= SEL_ALU;
        end else if (w_mem_grant) begin
            r_rf_we    <= (mem_rd != AW'(REG_ZERO));
            r_rf_waddr <= mem_rd;
            r_rf_wdata <= mem_data;
            r_wb_sel   <= SEL_MEM;
        end else if (w_alu_grant) begin
            r_rf_we    <= (w_head_rd != AW'(REG_ZERO));
            r_rf_waddr <= w_head_rd;
            r_rf_wdata <= w_head_data;
            r_wb_sel   <= SEL_ALU;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    assign wb_sel   = r_wb_sel;
    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scenario bench for wb_arbiter: expected register writes are queued as
// stimulus is driven and popped whenever the DUT asserts rf_we.
module tb_wb_arbiter;

    typedef struct packed {
        logic        sel;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wb_sel;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  fifo_count;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .wb_sel     (wb_sel),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got=%b want=0", rf_we); end
        n_checks++; if (fifo_count !== 2'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alu_ready got=%b want=1", alu_ready); end
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ready got=%b want=1", mem_ready); end
        n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr got=%0d want=0", rf_waddr); end
        n_checks++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got=%h want=0", rf_wdata); end
        n_checks++; if (wb_sel !== 1'b0) begin n_fail++; $display("FAIL reset_wb_sel got=%b want=0", wb_sel); end
    endtask

    task automatic test_alu_latency();
        wr_t got, e;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rf_we) begin
                got = {wb_sel, rf_waddr, rf_wdata};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL alu_unexpected_write got=%h want=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL alu_write got=%h want=%h", got, e); end
                end
            end
            if (c == 1) begin
                n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_early_we got=%b want=0", rf_we); end
                n_checks++; if (fifo_count !== 2'd1) begin n_fail++; $display("FAIL alu_count got=%0d want=1", fifo_count); end
            end
            if (c == 2) begin
                n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL alu_latency_we got=%b want=1", rf_we); end
            end
            alu_valid = (c == 0);
            alu_rd    = 5'd3;
            alu_data  = 32'h11;
            if (c == 0) exp_q.push_back('{1'b0, 5'd3, 32'h11});
        end
        alu_valid = 1'b0;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL alu_missing got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_same_cycle();
        wr_t got, e;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rf_we) begin
                got = {wb_sel, rf_waddr, rf_wdata};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL same_unexpected_write got=%h want=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL same_write got=%h want=%h", got, e); end
                end
            end
            if (c == 1) begin
                n_checks++; if (rf_we !== 1'b1 || wb_sel !== 1'b1) begin n_fail++; $display("FAIL same_mem_first got=we%b/sel%b want=we1/sel1", rf_we, wb_sel); end
            end
            if (c == 2) begin
                n_checks++; if (rf_we !== 1'b1 || wb_sel !== 1'b0) begin n_fail++; $display("FAIL same_alu_second got=we%b/sel%b want=we1/sel0", rf_we, wb_sel); end
            end
            alu_valid = (c == 0); alu_rd = 5'd4; alu_data = 32'hA;
            mem_valid = (c == 0); mem_rd = 5'd5; mem_data = 32'hB;
            if (c == 0) begin
                exp_q.push_back('{1'b1, 5'd5, 32'hB});
                exp_q.push_back('{1'b0, 5'd4, 32'hA});
                #1;
                n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL same_mem_ready got=%b want=1", mem_ready); end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL same_missing got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_starvation();
        wr_t got, e;
        bit  pat [0:11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int  k = 0;
        int  a = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (rf_we) begin
                got = {wb_sel, rf_waddr, rf_wdata};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL starve_unexpected_write got=%h want=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL starve_write c=%0d got=%h want=%h", c, got, e); end
                end
            end
            alu_valid = (c < 2);
            alu_rd    = (c == 0) ? 5'd6 : 5'd8;
            alu_data  = (c == 0) ? 32'h60 : 32'h80;
            mem_valid = (c < 12);
            mem_rd    = 5'(10 + k);
            mem_data  = 32'h1000 + 32'(k);
            if (c < 12) begin
                #1;
                n_checks++;
                if (mem_ready !== pat[c]) begin n_fail++; $display("FAIL starve_mem_ready c=%0d got=%b want=%b", c, mem_ready, pat[c]); end
                if (pat[c]) begin
                    exp_q.push_back('{1'b1, 5'(10 + k), 32'h1000 + 32'(k)});
                    k++;
                end else begin
                    if (a == 0) exp_q.push_back('{1'b0, 5'd6, 32'h60});
                    else        exp_q.push_back('{1'b0, 5'd8, 32'h80});
                    a++;
                end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL starve_missing got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_fifo_full();
        wr_t got, e;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (rf_we) begin
                got = {wb_sel, rf_waddr, rf_wdata};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL full_unexpected_write got=%h want=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL full_write c=%0d got=%h want=%h", c, got, e); end
                end
            end
            alu_valid = (c < 5);
            alu_rd    = (c == 0) ? 5'd1 : (c == 1) ? 5'd2 : 5'd31;
            alu_data  = (c == 0) ? 32'hF1 : (c == 1) ? 32'hF2 : 32'hDEAD;
            mem_valid = (c < 4);
            mem_rd    = 5'(20 + c);
            mem_data  = 32'h2000 + 32'(c);
            if (c < 4) exp_q.push_back('{1'b1, 5'(20 + c), 32'h2000 + 32'(c)});
            if (c == 3) begin
                exp_q.push_back('{1'b0, 5'd1, 32'hF1});
                exp_q.push_back('{1'b0, 5'd2, 32'hF2});
            end
            if (c >= 2 && c <= 4) begin
                #1;
                n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL full_alu_ready c=%0d got=%b want=0", c, alu_ready); end
                n_checks++; if (fifo_count !== 2'd2) begin n_fail++; $display("FAIL full_count c=%0d got=%0d want=2", c, fifo_count); end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_missing got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_rzero_reset();
        wr_t got, e;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rf_we) begin
                got = {wb_sel, rf_waddr, rf_wdata};
                n_checks++; n_fail++;
                $display("FAIL rzero_unexpected_write got=%h want=none", got);
            end
            if (c == 1) begin
                n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL rzero_waddr got=%0d want=0", rf_waddr); end
                n_checks++; if (rf_wdata !== 32'h55) begin n_fail++; $display("FAIL rzero_wdata got=%h want=55", rf_wdata); end
                n_checks++; if (wb_sel !== 1'b1) begin n_fail++; $display("FAIL rzero_sel got=%b want=1", wb_sel); end
            end
            mem_valid = (c == 0); mem_rd = 5'd0; mem_data = 32'h55;
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rf_we) begin
                got = {wb_sel, rf_waddr, rf_wdata};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rst_stale_write got=%h want=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL rst_write c=%0d got=%h want=%h", c, got, e); end
                end
            end
            if (c == 2) begin
                n_checks++; if (fifo_count !== 2'd2) begin n_fail++; $display("FAIL rst_pre_count got=%0d want=2", fifo_count); end
            end
            if (c == 3) begin
                n_checks++; if (fifo_count !== 2'd0) begin n_fail++; $display("FAIL rst_count got=%0d want=0", fifo_count); end
                n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got=%b want=0", rf_we); end
                n_checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_addr_data got=%0d/%h want=0/0", rf_waddr, rf_wdata); end
            end
            rst       = (c == 2);
            alu_valid = (c < 2);
            alu_rd    = (c == 0) ? 5'd12 : 5'd14;
            alu_data  = (c == 0) ? 32'hC0 : 32'hE0;
            mem_valid = (c < 2);
            mem_rd    = (c == 0) ? 5'd13 : 5'd15;
            mem_data  = (c == 0) ? 32'hD0 : 32'hF0;
            if (c == 0) exp_q.push_back('{1'b1, 5'd13, 32'hD0});
            if (c == 1) exp_q.push_back('{1'b1, 5'd15, 32'hF0});
        end
        rst = 1'b0;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_missing got=%0d pending want=0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_alu_latency();
        test_same_cycle();
        test_starvation();
        test_fifo_full();
        test_rzero_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
